// File: rtl/req_priority_encoder_pkg.sv
// Shared types and defaults for the request priority encoder.
package req_priority_encoder_pkg;

   localparam int unsigned N_IN_DEFAULT = 8;

   typedef enum logic [0:0] {
      IDLE,
      OFFER
   } state_e;

endpackage

// File: rtl/req_priority_encoder_if.sv
// Request/handshake bundle between a request source/consumer and the encoder.
interface req_priority_encoder_if
   import req_priority_encoder_pkg::*;
#(
   parameter int unsigned N_IN = N_IN_DEFAULT
);
   localparam int unsigned IDX_W = $clog2(N_IN);

   logic             en;
   logic [N_IN-1:0]  req;
   logic             ack;
   logic             clr_ovr;
   logic [IDX_W-1:0] number;
   logic             valid;
   logic [N_IN-1:0]  pending;
   logic             ovr;

   modport master (
      output en, req, ack, clr_ovr,
      input  number, valid, pending, ovr
   );

   modport slave (
      input  en, req, ack, clr_ovr,
      output number, valid, pending, ovr
   );

endinterface

// File: rtl/req_priority_encoder_prio_find.sv
// Combinational highest-set-bit finder: bit N_IN-1 has top priority.
module req_priority_encoder_prio_find #(
   parameter int unsigned N_IN  = 8,
   parameter int unsigned IDX_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      any = 1'b0;
      // Ascending scan: later (higher) set bits overwrite lower ones.
      for (int i = 0; i < int'(N_IN); i++) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_priority_encoder.sv
// Sticky request capture with highest-index-first valid/ack presentation.
module req_priority_encoder
   import req_priority_encoder_pkg::*;
#(
   parameter int unsigned N_IN = N_IN_DEFAULT
) (
   input logic                   clk,
   input logic                   rst_n,
   req_priority_encoder_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(N_IN);

   state_e           state_q, state_d;
   logic [N_IN-1:0]  pending_q, pending_d;
   logic [IDX_W-1:0] number_q, number_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   logic             acked;
   logic [N_IN-1:0]  clear_mask;
   logic [N_IN-1:0]  captured;
   logic             ovr_set;
   logic [IDX_W-1:0] win_q_idx, win_d_idx;
   logic             win_q_any, win_d_any;

   assign acked      = valid_q & bus.ack;
   assign clear_mask = acked ? (N_IN'(1) << number_q) : '0;
   assign captured   = bus.en ? bus.req : '0;
   // Set wins over the acked clear, so a re-request of the granted bit survives.
   assign pending_d  = (pending_q & ~clear_mask) | captured;
   assign ovr_set    = |(captured & pending_q & ~clear_mask);
   assign ovr_d      = ovr_set ? 1'b1 : (bus.clr_ovr ? 1'b0 : ovr_q);

   req_priority_encoder_prio_find #(
      .N_IN  (N_IN),
      .IDX_W (IDX_W)
   ) u_find_cur (
      .vec (pending_q),
      .idx (win_q_idx),
      .any (win_q_any)
   );

   req_priority_encoder_prio_find #(
      .N_IN  (N_IN),
      .IDX_W (IDX_W)
   ) u_find_next (
      .vec (pending_d),
      .idx (win_d_idx),
      .any (win_d_any)
   );

   always_comb begin
      state_d  = state_q;
      number_d = number_q;
      valid_d  = valid_q;
      unique case (state_q)
         IDLE: begin
            number_d = '0;
            valid_d  = 1'b0;
            if (win_q_any) begin
               state_d  = OFFER;
               number_d = win_q_idx;
               valid_d  = 1'b1;
            end
         end
         OFFER: begin
            valid_d = 1'b1;
            // Number is frozen until accepted; re-arbitrate only on ack.
            if (acked) begin
               if (win_d_any) begin
                  number_d = win_d_idx;
               end else begin
                  state_d  = IDLE;
                  number_d = '0;
                  valid_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            number_d = '0;
            valid_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         number_q  <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         number_q  <= number_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
      end
   end

   assign bus.number  = number_q;
   assign bus.valid   = valid_q;
   assign bus.pending = pending_q;
   assign bus.ovr     = ovr_q;

endmodule
